instr_encoder: RTL and testbench
================================

# instr_encoder

Encodes RV32I instruction fields (opcode, funct3, funct7, register indices, immediate) into 32-bit instruction words, the inverse of the decode stage's field and immediate extraction. Encoded words are buffered in a small FIFO for the debug program buffer and the self-test instruction injector, which feed the fetch path. Out-of-range or misaligned immediates and unsupported opcodes are flagged and replaced with a canonical NOP.

## Interface
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  7  major opcode.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; R-type, and the upper bits of I-type shifts.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  byte-offset or value immediate, in the same form the decoder produces.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  32  encoded instruction at the head; 0 when out_valid=0.
- out_err  out  1  the head entry was flagged; 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- err_cnt  out  8  flagged entries pushed since reset; saturates at 255.

## Operation
- Encoding is combinational on the input fields. The result and its error flag are written to the FIFO on push (in_valid && in_ready).
- Format is selected by in_opcode:
  - **R** (0110011): {funct7, rs2, rs1, funct3, rd, op}.
  - **I** (0010011, 0000011, 1100111): {imm[11:0], rs1, funct3, rd, op}. Range check: imm[31:11] all equal.
  - **I-shift** (0010011 with funct3 001 or 101): {funct7, imm[4:0], rs1, funct3, rd, op}. Error if imm[31:5]≠0.
  - **S** (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], op}. Range check: as I.
  - **B** (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}. Error if imm[31:12] not all equal or imm[0]=1.
  - **U** (0110111, 0010111): {imm[31:12], rd, op}. Error if imm[11:0]≠0.
  - **J** (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. Error if imm[31:20] not all equal or imm[0]=1.
  - Any other opcode is an error.
- On error the stored word is 32'h00000013 (addi x0,x0,0) and the stored err bit is 1.
- FIFO: circular buffer of DEPTH entries, each 33 bits; rd/wr pointers wrap modulo DEPTH.
- Handshakes:
  - in_ready = (count < DEPTH). It is registered-derived and has no combinational dependence on out_ready.
  - out_valid = (count ≠ 0).
  - Pop on out_valid && out_ready.
- err_cnt increments on each push of a flagged entry and holds at 255.

## Timing
- Push at rising edge N → entry visible at the head from cycle N+1 (out_valid=1 if the FIFO was empty). Latency is 1 cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance. At count=DEPTH a pop frees a slot, but in_ready stays 0 that cycle and returns to 1 the next cycle.
- Full: in_ready=0 and in_valid is ignored; no overwrite.
- Empty: out_ready is ignored and the pointers do not move.
- Ordering is strict FIFO. Sustained throughput is 1 word/cycle when the consumer is always ready.
- Reset (rst_n=0 at an edge, including mid-stream): pointers=0, count=0, err_cnt=0, out_valid=0, out_instr=0, out_err=0, in_ready=1 from the following cycle. Buffered entries are discarded. Memory contents are not reset.

## Test plan
- **addi x1,x0,5** (op 0010011, f3 000, rd 1, rs1 0, imm 5) → head 0x00500093, out_err=0, out_valid rises one cycle after push.
- **sub x3,x1,x2** (op 0110011, f7 0100000, rs2 2, rs1 1, f3 000, rd 3) → 0x402081B3. Then **beq x1,x2,-8** (imm 0xFFFFFFF8) → 0xFE208CE3. Then **lui x5** with imm 0x12345000 → 0x123452B7, in that order.
- **Error cases:**
  - addi with imm 2048 → 0x00000013, out_err=1, err_cnt=1.
  - jal with imm 3 → NOP, err_cnt=2.
  - opcode 1111111 → NOP, err_cnt=3.
  - Pushing 260 errors → err_cnt holds at 255.
- **Backpressure** (DEPTH=4): out_ready=0 with 6 pushes offered → 4 accepted, in_ready=0, count=4. Then out_ready=1 with continuous in_valid → 1 word/cycle, order preserved, no loss or duplication across pointer wrap.
- **Simultaneous push/pop at count=2** → count stays 2 and the correct word pops. Pop attempt when empty → no state change.
- **Reset mid-stream** with 3 entries and err_cnt=1: rst_n low for 1 cycle → count=0, out_valid=0, err_cnt=0, in_ready=1. A following push of addi x1,x0,5 emerges as 0x00500093.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into 32-bit instruction words
// and buffers them in a small FIFO for the debug program buffer / self-test
// injector. Out-of-range or misaligned immediates and unknown opcodes are
// replaced with a canonical NOP and flagged.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 in_opcode,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0

  // Immediate range checks: the bits above the encodable field must be a
  // pure sign extension of the field's top bit.
  logic imm_fits_12;
  logic imm_fits_13;
  logic imm_fits_21;

  assign imm_fits_12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign imm_fits_13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign imm_fits_21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  logic [31:0] raw_word;
  logic        enc_err;
  logic [31:0] enc_word;

  // Format selection and field packing; any flagged bundle becomes a NOP.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    raw_word = NOP_WORD;
    enc_err  = 1'b0;
    case (in_opcode)
      OP_R: begin
        raw_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_IMM: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          // Shifts carry a 5-bit shamt; funct7 fills the upper imm bits.
          raw_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err  = |in_imm[31:5];
        end else begin
          raw_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err  = !imm_fits_12;
        end
      end
      OP_LOAD, OP_JALR: begin
        raw_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = !imm_fits_12;
      end
      OP_STORE: begin
        raw_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = !imm_fits_12;
      end
      OP_BRANCH: begin
        raw_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = !imm_fits_13 || in_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        raw_word = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = |in_imm[11:0];
      end
      OP_JAL: begin
        raw_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = !imm_fits_21 || in_imm[0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  assign enc_word = enc_err ? NOP_WORD : raw_word;

  // FIFO storage and control.
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [32:0]   head;

  // in_ready comes only from the registered occupancy, so a pop while full
  // frees the slot for the next cycle, not this one.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign out_instr = out_valid ? head[31:0] : 32'h0;
  assign out_err   = out_valid ? head[32]   : 1'b0;

  // Entry write: {err, word}.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy is tracked by count,
    // so stale contents are never visible and resetting them buys nothing.
    if (push) begin
      mem[wr_ptr] <= {enc_err, enc_word};
    end
  end

  // Pointers, occupancy and flagged-entry counter.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && enc_err && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4).
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [2:0]  count;
  logic [7:0]  err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .count     (count),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic push_one(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
    drive(op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
  endtask

  // addi x0,x0,k: used as uniquely identifiable payload words.
  function automatic logic [31:0] addi0_word(input int k);
    return (32'(k) << 20) | 32'h0000_0013;
  endfunction

  initial begin
    int k;
    int exp_k;
    int cycles;
    bit acc;

    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(7'h00, 3'h0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    do_reset();

    // Reset state
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_instr", out_instr,      32'h0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);

    // addi x1,x0,5 with one-cycle latency
    drive(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    check("addi_pre_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_word",  out_instr,      32'h0050_0093);
    check("addi_err",   32'(out_err),   32'd0);
    check("addi_count", 32'(count),     32'd1);
    pop_one();
    check("addi_pop_valid", 32'(out_valid), 32'd0);
    check("addi_pop_instr", out_instr,      32'h0);

    // sub, beq, lui in order
    push_one(7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'h0);
    push_one(7'b1100011, 3'b000, 7'h00,      5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    push_one(7'b0110111, 3'b000, 7'h00,      5'd5, 5'd0, 5'd0, 32'h1234_5000);
    check("seq_count", 32'(count), 32'd3);
    check("sub_word", out_instr, 32'h4020_81B3);
    pop_one();
    check("beq_word", out_instr, 32'hFE20_8CE3);
    pop_one();
    check("lui_word", out_instr, 32'h1234_52B7);
    pop_one();

    // More legal formats, including the imm = -2048 boundary
    push_one(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
    check("addi_m2048_word", out_instr,    32'h8000_0093);
    check("addi_m2048_err",  32'(out_err), 32'd0);
    pop_one();
    push_one(7'b0010011, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 32'd3);
    check("slli_word", out_instr, 32'h0030_9093);
    pop_one();
    push_one(7'b0100011, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    check("sw_word", out_instr, 32'hFE20_AE23);
    pop_one();
    push_one(7'b1101111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8);
    check("jal_word", out_instr, 32'h0080_00EF);
    check("good_err_cnt", 32'(err_cnt), 32'd0);
    pop_one();

    // Error cases
    push_one(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    check("e_addi_word", out_instr,     32'h0000_0013);
    check("e_addi_err",  32'(out_err),  32'd1);
    check("e_addi_cnt",  32'(err_cnt),  32'd1);
    pop_one();
    push_one(7'b1101111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3);
    check("e_jal_word", out_instr,    32'h0000_0013);
    check("e_jal_err",  32'(out_err), 32'd1);
    check("e_jal_cnt",  32'(err_cnt), 32'd2);
    pop_one();
    push_one(7'b1111111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0);
    check("e_op_word", out_instr,    32'h0000_0013);
    check("e_op_cnt",  32'(err_cnt), 32'd3);
    pop_one();
    push_one(7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd32);
    check("e_srai_err", 32'(out_err), 32'd1);
    check("e_srai_cnt", 32'(err_cnt), 32'd4);
    pop_one();
    push_one(7'b1100011, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4096);
    check("e_beq_err", 32'(out_err), 32'd1);
    check("e_beq_cnt", 32'(err_cnt), 32'd5);
    pop_one();

    // 260 more errors with the consumer always ready: saturate at 255
    drive(7'b1111111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sat_count",   32'(count),   32'd0);

    // Backpressure: 6 offers with consumer stalled, only 4 accepted
    k = 1;
    for (int i = 0; i < 6; i++) begin
      drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'(k));
      in_valid = 1'b1;
      acc = in_ready;
      tick();
      if (acc) k++;
    end
    check("bp_accepted",  32'(k - 1),     32'd4);
    check("bp_count",     32'(count),     32'd4);
    check("bp_in_ready",  32'(in_ready),  32'd0);

    // Release consumer with continuous offers: one word per cycle, in order
    out_ready = 1'b1;
    exp_k  = 1;
    cycles = 0;
    while (exp_k <= 14 && cycles < 100) begin
      if (out_valid) begin
        check("bp_order", out_instr, addi0_word(exp_k));
        exp_k++;
      end else begin
        check("bp_gap_valid", 32'(out_valid), 32'd1);
      end
      acc = in_valid && in_ready;
      tick();
      cycles++;
      if (cycles == 1) check("bp_ready_back", 32'(in_ready), 32'd1);
      if (acc) begin
        k++;
        if (k > 14) in_valid = 1'b0;
        else drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'(k));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_total",  32'(exp_k - 1), 32'd14);
    check("bp_cycles", 32'(cycles),    32'd14);
    check("bp_empty",  32'(count),     32'd0);

    // Simultaneous push and pop at count=2
    push_one(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd100);
    push_one(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd101);
    drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd102);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("pp_head_a", out_instr, addi0_word(100));
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pp_count", 32'(count), 32'd2);
    check("pp_head_b", out_instr, addi0_word(101));
    pop_one();
    check("pp_head_c", out_instr, addi0_word(102));
    pop_one();
    check("pp_drained", 32'(out_valid), 32'd0);

    // Pop attempt while empty changes nothing
    pop_one();
    check("empty_pop_count", 32'(count),    32'd0);
    check("empty_pop_instr", out_instr,     32'h0);
    check("empty_pop_ready", 32'(in_ready), 32'd1);
    push_one(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd103);
    check("empty_pop_next", out_instr, addi0_word(103));
    pop_one();

    // Reset mid-stream with 3 entries and err_cnt=1
    do_reset();
    push_one(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd7);
    push_one(7'b1111111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    push_one(7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    check("mid_pre_count", 32'(count),   32'd3);
    check("mid_pre_err",   32'(err_cnt), 32'd1);
    do_reset();
    check("mid_count",     32'(count),     32'd0);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_err_cnt",   32'(err_cnt),   32'd0);
    check("mid_in_ready",  32'(in_ready),  32'd1);
    check("mid_out_instr", out_instr,      32'h0);
    push_one(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    check("mid_after_word",  out_instr,     32'h0050_0093);
    check("mid_after_count", 32'(count),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
